led_mode_sched: RTL and testbench
=================================

# led_mode_sched

Button-driven mode scheduler that sits between the five board push-buttons and the LED/ja pattern datapath. It synchronises and debounces each button, arbitrates simultaneous presses by fixed priority, and runs a mode state machine. Its outputs are a mode code, a pattern step index and a gate/blink signal, which the pattern generator consumes instead of raw buttons.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level (10 ms at 100 MHz); must be ≥2.
- STEP_CYCLES, 4_194_304: cycles per sequence step in SEQ mode; must be ≥1.
- FAST_BIT, 23 / MID_BIT, 24 / SLOW_BIT, 25: divider bit driving led_gate in each blink mode; each must be ≤25.
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- btnu, btnd, btnl, btnr, btnc  in  1 each  raw, asynchronous, active-high buttons.
- mode  out  3  current mode code (see Operation).
- mode_chg  out  1  one-cycle pulse in the cycle mode takes a new value.
- step  out  4  sequence step index; meaningful in SEQ/PAUSE.
- paused  out  1  high in PAUSE.
- led_gate  out  1  output enable / blink phase for the pattern datapath.

## Operation
- Mode codes: OFF=0, SOLID=1, BLINK_MID=2, BLINK_SLOW=3, BLINK_FAST=4, SEQ=5, PAUSE=6. Code 7 is unused; if reached, the block returns to OFF.
- Each button uses a 2-flop synchroniser, then a debouncer. The debouncer has a counter that clears whenever the synchronised level equals the stable level. When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears. A rising edge of the stable level produces a one-cycle press pulse.
- Arbitration: if several press pulses occur in the same cycle, priority is u > d > l > r > c. Only the winner acts; losers are dropped, not queued.
- Transitions on a winning press:
  - u: to SOLID. If already SOLID, to OFF.
  - d: to BLINK_MID. If already BLINK_MID, to OFF.
  - l: to BLINK_SLOW. If already BLINK_SLOW, to OFF.
  - r: to BLINK_FAST. If already BLINK_FAST, to OFF.
  - c: SEQ→PAUSE, PAUSE→SEQ; from any other mode, enter SEQ with step=0 and the step timer at 0.
- mode_chg pulses on every change of mode, including SEQ↔PAUSE.
- Divider: 26-bit free counter. It clears in the cycle mode_chg is asserted and increments otherwise, so every blink starts in its low phase.
- led_gate values:
  - OFF: 0
  - SOLID: 1
  - BLINK_MID: div[MID_BIT]
  - BLINK_SLOW: div[SLOW_BIT]
  - BLINK_FAST: div[FAST_BIT]
  - SEQ and PAUSE: 1
- Step timer (SEQ only): increments each cycle. On reaching STEP_CYCLES-1 it clears and step increments; step wraps 15→0.
- In PAUSE, the timer and step hold their values. Leaving SEQ/PAUSE for any other mode clears both.
- Releases produce no action. A button held continuously counts as one press.

## Timing
- Reset (async assert; synchronous-release behaviour handled by the flops) sets:
  - mode=OFF, mode_chg=0, step=0, paused=0, led_gate=0.
  - Divider, timers, synchronisers and debouncer stable levels all 0.
- A button held through reset release is accepted as a press after the normal debounce latency.
- Latency, with raw rising first sampled at edge 0 and held:
  - stable flips at edge DEBOUNCE_CYCLES+1
  - press pulse registered at edge DEBOUNCE_CYCLES+2
  - mode, mode_chg and paused updated at edge DEBOUNCE_CYCLES+3
  - led_gate is registered and reflects the new mode from the same edge
- A glitch shorter than DEBOUNCE_CYCLES consecutive cycles produces no press.
- In SEQ, step advances every STEP_CYCLES cycles, with the first advance STEP_CYCLES cycles after the mode_chg edge.
- Throughput: at most one mode change per cycle. Presses on different buttons one cycle apart are each honoured in order.

## Structure
- Package btn_led_pkg holds:
  - the mode code constants/enum (3 bits)
  - button index constants in priority order (U=0, D=1, L=2, R=3, C=4)
  - the step width (4)
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports sys_clk, sys_rst_n, raw, stable, press) contains synchroniser + debouncer + edge detect and is instantiated five times.
- The top level contains the arbiter, mode FSM, divider and step timer.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, STEP_CYCLES=3, FAST_BIT=1, MID_BIT=2, SLOW_BIT=3.
- btnu high for 10 cycles → mode=1 and mode_chg high for exactly one cycle, 7 edges after first sample; led_gate=1. Second btnu press → mode=0, led_gate=0.
- btnd pulsed for 3 cycles → no mode_chg and mode stays 0. Held for 6 cycles → mode=2, and led_gate toggles every 4 cycles starting low.
- btnu and btnc rise on the same edge and are held → mode=1 only. btnc is never acted on until it is released and pressed again.
- btnc press → mode=5, step=0, then steps 1,2,…,15,0 every 3 cycles. Second btnc → mode=6, paused=1, step frozen. Third btnc → mode=5, and step resumes from the frozen value.
- In SEQ at step=7, press btnr → mode=4, step=0. Then press btnc → mode=5 with step=0.
- sys_rst_n asserted mid-SEQ → all outputs zero immediately. btnl held across deassert → mode=3 at edge 7 after release.

Source files
------------

// File: rtl/btn_led_pkg.sv
// Shared mode codes, button priority indices and widths for the button-driven LED mode scheduler.
// Pure declarations; no clocked logic.
package btn_led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF        = 3'd0,
    MODE_SOLID      = 3'd1,
    MODE_BLINK_MID  = 3'd2,
    MODE_BLINK_SLOW = 3'd3,
    MODE_BLINK_FAST = 3'd4,
    MODE_SEQ        = 3'd5,
    MODE_PAUSE      = 3'd6,
    MODE_RSVD       = 3'd7
  } mode_e;

  // Index order is also arbitration priority: lowest index wins.
  localparam int BTN_U   = 0;
  localparam int BTN_D   = 1;
  localparam int BTN_L   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_C   = 4;
  localparam int BTN_NUM = 5;

  localparam int STEP_W = 4;
  localparam int DIV_W  = 26;

  function automatic mode_e toggle_mode(input mode_e cur, input mode_e tgt);
    return (cur == tgt) ? MODE_OFF : tgt;
  endfunction

  function automatic logic in_seq(input mode_e m);
    return (m == MODE_SEQ) || (m == MODE_PAUSE);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability debouncer and rising-edge press pulse.
// stable flips DEBOUNCE_CYCLES+1 edges after the raw level changes; press follows one edge later; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d   = {sync_q[0], raw};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    press_d  = stable_q & ~prev_q;
    // Any sample agreeing with the accepted level restarts the qualification window.
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = ~stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/led_mode_sched.sv
// Debounced-button mode scheduler: fixed-priority press arbiter, mode FSM, blink divider and sequence step timer.
// Mode/gate update DEBOUNCE_CYCLES+3 edges after a raw press; losing simultaneous presses are dropped, no backpressure.
module led_mode_sched
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 4_194_304,
  parameter int FAST_BIT        = 23,
  parameter int MID_BIT         = 24,
  parameter int SLOW_BIT        = 25
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              btnu,
  input  logic              btnd,
  input  logic              btnl,
  input  logic              btnr,
  input  logic              btnc,
  output logic [2:0]        mode,
  output logic              mode_chg,
  output logic [STEP_W-1:0] step,
  output logic              paused,
  output logic              led_gate
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);

  logic [BTN_NUM-1:0] btn_raw;
  logic [BTN_NUM-1:0] btn_stable;
  logic [BTN_NUM-1:0] btn_press;
  logic [BTN_NUM-1:0] press_vld;
  logic [BTN_NUM-1:0] grant;

  mode_e              mode_q, mode_d;
  logic               mode_chg_q, mode_chg_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               paused_q, paused_d;
  logic               gate_q, gate_d;

  assign btn_raw[BTN_U] = btnu;
  assign btn_raw[BTN_D] = btnd;
  assign btn_raw[BTN_L] = btnl;
  assign btn_raw[BTN_R] = btnr;
  assign btn_raw[BTN_C] = btnc;

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .raw      (btn_raw[i]),
      .stable   (btn_stable[i]),
      .press    (btn_press[i])
    );
  end

  assign press_vld = btn_press & btn_stable;
  // Isolate the lowest set bit: index 0 (up) has top priority.
  assign grant = press_vld & (~press_vld + BTN_NUM'(1));

  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_RSVD) begin
      mode_d = MODE_OFF;
    end else if (grant[BTN_U]) begin
      mode_d = toggle_mode(mode_q, MODE_SOLID);
    end else if (grant[BTN_D]) begin
      mode_d = toggle_mode(mode_q, MODE_BLINK_MID);
    end else if (grant[BTN_L]) begin
      mode_d = toggle_mode(mode_q, MODE_BLINK_SLOW);
    end else if (grant[BTN_R]) begin
      mode_d = toggle_mode(mode_q, MODE_BLINK_FAST);
    end else if (grant[BTN_C]) begin
      case (mode_q)
        MODE_SEQ:   mode_d = MODE_PAUSE;
        MODE_PAUSE: mode_d = MODE_SEQ;
        default:    mode_d = MODE_SEQ;
      endcase
    end
  end

  always_comb begin
    mode_chg_d = (mode_d != mode_q);
    paused_d   = (mode_d == MODE_PAUSE);
    div_d      = mode_chg_d ? '0 : div_q + 1'b1;
  end

  // Timer only runs on SEQ->SEQ edges, so entering or leaving PAUSE freezes it for that edge too.
  always_comb begin
    tmr_d  = tmr_q;
    step_d = step_q;
    if (!in_seq(mode_d) || !in_seq(mode_q)) begin
      tmr_d  = '0;
      step_d = '0;
    end else if ((mode_q == MODE_SEQ) && (mode_d == MODE_SEQ)) begin
      if (tmr_q == STEP_LAST) begin
        tmr_d  = '0;
        step_d = step_q + 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_comb begin
    gate_d = 1'b0;
    case (mode_d)
      MODE_SOLID, MODE_SEQ, MODE_PAUSE: gate_d = 1'b1;
      MODE_BLINK_MID:                   gate_d = div_d[MID_BIT];
      MODE_BLINK_SLOW:                  gate_d = div_d[SLOW_BIT];
      MODE_BLINK_FAST:                  gate_d = div_d[FAST_BIT];
      default:                          gate_d = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q     <= MODE_OFF;
      mode_chg_q <= 1'b0;
      div_q      <= '0;
      tmr_q      <= '0;
      step_q     <= '0;
      paused_q   <= 1'b0;
      gate_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
      div_q      <= div_d;
      tmr_q      <= tmr_d;
      step_q     <= step_d;
      paused_q   <= paused_d;
      gate_q     <= gate_d;
    end
  end

  assign mode     = mode_q;
  assign mode_chg = mode_chg_q;
  assign step     = step_q;
  assign paused   = paused_q;
  assign led_gate = gate_q;

endmodule

// File: tb/tb_led_mode_sched.sv
// Bench for led_mode_sched: directed scenarios plus random button activity against a behavioural model.
module tb_led_mode_sched;

  localparam int D  = 4;
  localparam int S  = 3;
  localparam int FB = 1;
  localparam int MB = 2;
  localparam int SB = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0, btnc = 1'b0;
  logic [2:0] mode;
  logic       mode_chg;
  logic [3:0] step;
  logic       paused;
  logic       led_gate;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  led_mode_sched #(
    .DEBOUNCE_CYCLES(D),
    .STEP_CYCLES    (S),
    .FAST_BIT       (FB),
    .MID_BIT        (MB),
    .SLOW_BIT       (SB)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .btnu     (btnu),
    .btnd     (btnd),
    .btnl     (btnl),
    .btnr     (btnr),
    .btnc     (btnc),
    .mode     (mode),
    .mode_chg (mode_chg),
    .step     (step),
    .paused   (paused),
    .led_gate (led_gate)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: button histories, press delay line, mode rules, cycle counts.
  int       m_mode, m_chg, m_step, m_paused, m_gate, m_age, m_seq_n;
  bit [7:0] rh[5];
  bit [7:0] sh[5];
  bit       stb[5];
  bit       p1[5];
  bit       p2[5];

  task automatic model_reset();
    m_mode = 0; m_chg = 0; m_step = 0; m_paused = 0; m_gate = 0; m_age = 0; m_seq_n = 0;
    for (int i = 0; i < 5; i++) begin
      rh[i] = '0; sh[i] = '0; stb[i] = 1'b0; p1[i] = 1'b0; p2[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit [4:0] r);
    bit [4:0] act;
    bit [7:0] mask;
    bit       seen;
    int       win;
    int       nm;
    mask = 8'((1 << D) - 1);
    for (int i = 0; i < 5; i++) begin
      act[i] = p2[i];
      p2[i]  = p1[i];
      p1[i]  = 1'b0;
      seen   = rh[i][1];
      rh[i]  = {rh[i][6:0], r[i]};
      sh[i]  = {sh[i][6:0], seen};
      // Accept a new level once the last D synchronised samples all disagree with the current one.
      if ((sh[i] & mask) == (stb[i] ? 8'h00 : mask)) begin
        stb[i] = !stb[i];
        p1[i]  = stb[i];
      end
    end
    win = -1;
    for (int i = 4; i >= 0; i--) if (act[i]) win = i;
    nm = m_mode;
    case (win)
      0: nm = (m_mode == 1) ? 0 : 1;
      1: nm = (m_mode == 2) ? 0 : 2;
      2: nm = (m_mode == 3) ? 0 : 3;
      3: nm = (m_mode == 4) ? 0 : 4;
      4: nm = (m_mode == 5) ? 6 : 5;
      default: ;
    endcase
    m_chg = (nm != m_mode) ? 1 : 0;
    m_age = m_chg ? 0 : m_age + 1;
    if (nm == 5 && m_mode == 5) m_seq_n++;
    else if (nm != 5 && nm != 6) m_seq_n = 0;
    else if (m_mode != 5 && m_mode != 6) m_seq_n = 0;
    m_mode   = nm;
    m_step   = (m_seq_n / S) % 16;
    m_paused = (nm == 6) ? 1 : 0;
    case (nm)
      1, 5, 6: m_gate = 1;
      2:       m_gate = (m_age >> MB) & 1;
      3:       m_gate = (m_age >> SB) & 1;
      4:       m_gate = (m_age >> FB) & 1;
      default: m_gate = 0;
    endcase
  endtask

  task automatic cycle();
    bit [4:0] r;
    r = {btnc, btnr, btnl, btnd, btnu};
    @(posedge sys_clk);
    model_edge(r);
    @(negedge sys_clk);
    check("mode", mode, m_mode);
    check("mode_chg", mode_chg, m_chg);
    check("step", step, m_step);
    check("paused", paused, m_paused);
    check("led_gate", led_gate, m_gate);
  endtask

  task automatic lat_check(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (mode_chg) begin
        seen = 1'b1;
        check(tag, k, D + 3);
      end
    end
    if (!seen) check(tag, -1, D + 3);
  endtask

  task automatic wait_step(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (step == 4'(target)) hit = 1'b1;
      else cycle();
    end
    check("wait_step", hit, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_chg"}, mode_chg, 0);
    check({tag, "_step"}, step, 0);
    check({tag, "_paused"}, paused, 0);
    check({tag, "_gate"}, led_gate, 0);
  endtask

  int hold[5];

  initial begin
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #2 check_zero("rst");
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) cycle();

    // Up: latency, solid, then toggle off.
    btnu = 1'b1;
    lat_check("lat_u");
    check("u_solid_gate", led_gate, 1);
    repeat (2) cycle();
    btnu = 1'b0;
    repeat (8) cycle();
    btnu = 1'b1;
    repeat (10) cycle();
    btnu = 1'b0;
    repeat (8) cycle();
    check("u_off", mode, 0);

    // Down: short glitch rejected, then a real press and blinking.
    btnd = 1'b1;
    repeat (3) cycle();
    btnd = 1'b0;
    repeat (10) cycle();
    check("glitch_mode", mode, 0);
    btnd = 1'b1;
    repeat (6) cycle();
    btnd = 1'b0;
    repeat (20) cycle();
    check("d_blink_mode", mode, 2);

    // Up and centre together: up wins, held centre stays ignored.
    btnu = 1'b1;
    btnc = 1'b1;
    repeat (10) cycle();
    btnu = 1'b0;
    repeat (10) cycle();
    check("uc_mode", mode, 1);
    btnc = 1'b0;
    repeat (8) cycle();
    btnc = 1'b1;
    repeat (6) cycle();
    btnc = 1'b0;
    repeat (4) cycle();
    check("c_seq_mode", mode, 5);
    check("c_seq_step", step, 0);

    // Sequence wraps, pause, resume, then right from step 7, then centre again.
    repeat (50) cycle();
    btnc = 1'b1; repeat (6) cycle(); btnc = 1'b0; repeat (4) cycle();
    check("pause_mode", mode, 6);
    repeat (10) cycle();
    btnc = 1'b1; repeat (6) cycle(); btnc = 1'b0; repeat (4) cycle();
    check("resume_mode", mode, 5);
    wait_step(7);
    btnr = 1'b1; repeat (6) cycle(); btnr = 1'b0; repeat (4) cycle();
    check("r_fast_mode", mode, 4);
    check("r_fast_step", step, 0);
    repeat (6) cycle();
    btnc = 1'b1; repeat (6) cycle(); btnc = 1'b0; repeat (4) cycle();
    check("c_reenter_mode", mode, 5);
    check("c_reenter_step", step, 0);
    repeat (12) cycle();

    // Reset mid-sequence, left held across release.
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    btnl = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    lat_check("lat_rst_l");
    check("rst_l_mode", mode, 3);
    btnl = 1'b0;
    repeat (10) cycle();

    // Random button activity with varied hold lengths.
    for (int i = 0; i < 5; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          hold[i] = $urandom_range(1, 12);
          case (i)
            0: btnu = 1'($urandom_range(0, 1));
            1: btnd = 1'($urandom_range(0, 1));
            2: btnl = 1'($urandom_range(0, 1));
            3: btnr = 1'($urandom_range(0, 1));
            default: btnc = 1'($urandom_range(0, 1));
          endcase
        end
        hold[i]--;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
